// File: rtl/servfarm_apb_master.sv
// Purpose : APB requester; turns a valid/ready command stream into single APB transfers, one outstanding.
// Latency : accept@T, SETUP@T+1, ACCESS@T+2, rsp_valid@T+3 with zero wait states (minimum 4 cycles/transfer).
// Backpressure: cmd_ready only in IDLE; the response is held in RESP until rsp_ready, which blocks the next command.
//
// Ports:
//   clk, rst                       single clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake; cmd_addr, cmd_write, cmd_wdata carry the request
//   rsp_valid/rsp_ready            response handshake; rsp_rdata, rsp_err, rsp_timeout carry the result
//   paddr, psel, penable, pwrite,  APB requester side
//   pwdata, prdata, pready, perr
//   busy                           high whenever the FSM is not IDLE
//   txn_count                      completed transfers including timeouts, wraps at 16 bits
module servfarm_apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB requester
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              perr,
  // status
  output logic              busy,
  output logic [15:0]       txn_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // A zero TIMEOUT_CYCLES disables the timeout; keep a 1-bit counter so the
  // declarations stay legal, it is simply never compared.
  localparam bit       TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int       TO_W  = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]      state;
  logic [TO_W-1:0] to_cnt;

  // The counter holds the number of wait cycles already seen, so the
  // TIMEOUT_CYCLES-th wait cycle is the one where it reads TIMEOUT_CYCLES-1.
  logic to_expire;
  assign to_expire = TO_EN && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      busy        <= 1'b0;
      txn_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // cmd_ready is registered, so it first rises one cycle after reset release.
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_write ? cmd_wdata : '0;
            psel      <= 1'b1;
            penable   <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            to_cnt    <= '0;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // pready is checked first so a completion on the expiring cycle wins.
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= perr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            txn_count   <= txn_count + 16'd1;
            state       <= ST_RESP;
          end else if (to_expire) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            txn_count   <= txn_count + 16'd1;
            state       <= ST_RESP;
          end else if (to_cnt != {TO_W{1'b1}}) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          psel      <= 1'b0;
          penable   <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servfarm_apb_master.sv
// Directed bench for servfarm_apb_master, built with TIMEOUT_CYCLES=4.
// Outputs are sampled and inputs driven on the falling edge.
module tb_servfarm_apb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        perr = 1'b0;
  logic        busy;
  logic [15:0] txn_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  servfarm_apb_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .perr(perr),
    .busy(busy), .txn_count(txn_count)
  );

  // Waits (bounded) for cmd_ready, presents one command for a single edge,
  // and returns on the falling edge where SETUP is visible.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_wait cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({cmd_ready, rsp_valid, psel, penable, busy, rsp_err, rsp_timeout} !== 7'b0 || txn_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_state cmd_ready=%b rsp_valid=%b psel=%b penable=%b busy=%b txn=%0d required all 0",
               cmd_ready, rsp_valid, psel, penable, busy, txn_count);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write;
    pready = 1'b1; perr = 1'b0; prdata = 32'h0;
    issue(32'h8000, 1'b1, 32'h5);
    total++;
    if (!(psel === 1'b1 && penable === 1'b0 && paddr === 32'h8000 && pwrite === 1'b1 &&
          pwdata === 32'h5 && cmd_ready === 1'b0 && busy === 1'b1)) begin
      bad++;
      $display("FAIL wr_setup psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h cmd_ready=%b busy=%b required 1 0 8000 1 5 0 1",
               psel, penable, paddr, pwrite, pwdata, cmd_ready, busy);
    end
    @(negedge clk);
    total++;
    if (!(psel === 1'b1 && penable === 1'b1 && rsp_valid === 1'b0)) begin
      bad++;
      $display("FAIL wr_access psel=%b penable=%b rsp_valid=%b required 1 1 0", psel, penable, rsp_valid);
    end
    @(negedge clk);
    total++;
    if (!(rsp_valid === 1'b1 && rsp_err === 1'b0 && rsp_timeout === 1'b0 && rsp_rdata === 32'h0 &&
          psel === 1'b0 && penable === 1'b0)) begin
      bad++;
      $display("FAIL wr_rsp rsp_valid=%b err=%b timeout=%b rdata=%h psel=%b penable=%b required 1 0 0 0 0 0",
               rsp_valid, rsp_err, rsp_timeout, rsp_rdata, psel, penable);
    end
    total++;
    if (txn_count !== 16'd1) begin
      bad++;
      $display("FAIL wr_txn_count got=%0d required 1", txn_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (!(rsp_valid === 1'b0 && cmd_ready === 1'b1 && busy === 1'b0)) begin
      bad++;
      $display("FAIL wr_handshake rsp_valid=%b cmd_ready=%b busy=%b required 0 1 0", rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_read;
    pready = 1'b1; perr = 1'b0; prdata = 32'h5;
    issue(32'h8000, 1'b0, 32'hDEAD_BEEF);
    total++;
    if (!(psel === 1'b1 && pwrite === 1'b0 && pwdata === 32'h0 && paddr === 32'h8000)) begin
      bad++;
      $display("FAIL rd_setup psel=%b pwrite=%b pwdata=%h paddr=%h required 1 0 0 8000", psel, pwrite, pwdata, paddr);
    end
    @(negedge clk);
    total++;
    if (!(penable === 1'b1 && pwdata === 32'h0)) begin
      bad++;
      $display("FAIL rd_access penable=%b pwdata=%h required 1 0", penable, pwdata);
    end
    @(negedge clk);
    total++;
    if (!(rsp_valid === 1'b1 && rsp_rdata === 32'h0000_0005 && rsp_err === 1'b0 && rsp_timeout === 1'b0 &&
          txn_count === 16'd2)) begin
      bad++;
      $display("FAIL rd_rsp rsp_valid=%b rdata=%h err=%b timeout=%b txn=%0d required 1 00000005 0 0 2",
               rsp_valid, rsp_rdata, rsp_err, rsp_timeout, txn_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Three wait states; pready arrives in the 4th ACCESS cycle, the same
  // cycle the 4-cycle timeout would expire, so completion must win.
  task automatic test_wait_err;
    pready = 1'b0; perr = 1'b0; prdata = 32'h0000_ABCD;
    issue(32'h8004, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (!(psel === 1'b1 && penable === 1'b1 && paddr === 32'h8004 && pwrite === 1'b0 && rsp_valid === 1'b0)) begin
        bad++;
        $display("FAIL ws_access[%0d] psel=%b penable=%b paddr=%h pwrite=%b rsp_valid=%b required 1 1 8004 0 0",
                 i, psel, penable, paddr, pwrite, rsp_valid);
      end
      if (i == 3) begin
        pready = 1'b1; perr = 1'b1;
      end
    end
    @(negedge clk);
    pready = 1'b0; perr = 1'b0;
    total++;
    if (!(rsp_valid === 1'b1 && rsp_err === 1'b1 && rsp_timeout === 1'b0 && rsp_rdata === 32'h0000_ABCD &&
          psel === 1'b0 && txn_count === 16'd3)) begin
      bad++;
      $display("FAIL ws_rsp rsp_valid=%b err=%b timeout=%b rdata=%h psel=%b txn=%0d required 1 1 0 0000abcd 0 3",
               rsp_valid, rsp_err, rsp_timeout, rsp_rdata, psel, txn_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int acc = 0;
    int n = 0;
    pready = 1'b0; perr = 1'b0; prdata = 32'hFFFF_FFFF;
    issue(32'h9000, 1'b0, 32'h0);
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 20) begin
      if (psel === 1'b1 && penable === 1'b1) acc++;
      @(negedge clk);
      n++;
    end
    total++;
    if (acc != 4) begin
      bad++;
      $display("FAIL to_access_cycles got=%0d required 4", acc);
    end
    total++;
    if (!(rsp_valid === 1'b1 && psel === 1'b0 && penable === 1'b0 && rsp_err === 1'b1 &&
          rsp_timeout === 1'b1 && rsp_rdata === 32'h0 && txn_count === 16'd4)) begin
      bad++;
      $display("FAIL to_rsp rsp_valid=%b psel=%b penable=%b err=%b timeout=%b rdata=%h txn=%0d required 1 0 0 1 1 0 4",
               rsp_valid, psel, penable, rsp_err, rsp_timeout, rsp_rdata, txn_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    prdata = 32'h0;
  endtask

  task automatic test_back_to_back;
    pready = 1'b1; perr = 1'b0; prdata = 32'h1234_5678;
    issue(32'h8008, 1'b1, 32'h77);
    // Keep a second command pending for the whole response stall.
    cmd_valid = 1'b1; cmd_addr = 32'hA000; cmd_write = 1'b0; cmd_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (!(cmd_ready === 1'b0 && rsp_valid === 1'b1 && rsp_rdata === 32'h0 && rsp_err === 1'b0 &&
            rsp_timeout === 1'b0 && psel === 1'b0 && txn_count === 16'd5)) begin
        bad++;
        $display("FAIL stall[%0d] cmd_ready=%b rsp_valid=%b rdata=%h err=%b timeout=%b psel=%b txn=%0d required 0 1 0 0 0 0 5",
                 i, cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, txn_count);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (!(rsp_valid === 1'b0 && cmd_ready === 1'b1 && psel === 1'b0)) begin
      bad++;
      $display("FAIL b2b_release rsp_valid=%b cmd_ready=%b psel=%b required 0 1 0", rsp_valid, cmd_ready, psel);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (!(psel === 1'b1 && penable === 1'b0 && paddr === 32'hA000 && pwrite === 1'b0)) begin
      bad++;
      $display("FAIL b2b_accept psel=%b penable=%b paddr=%h pwrite=%b required 1 0 a000 0", psel, penable, paddr, pwrite);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (!(rsp_valid === 1'b1 && rsp_rdata === 32'h1234_5678 && txn_count === 16'd6)) begin
      bad++;
      $display("FAIL b2b_rsp rsp_valid=%b rdata=%h txn=%0d required 1 12345678 6", rsp_valid, rsp_rdata, txn_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    pready = 1'b0; perr = 1'b0; prdata = 32'h0;
    issue(32'hB000, 1'b0, 32'h0);
    @(negedge clk);
    total++;
    if (!(psel === 1'b1 && penable === 1'b1)) begin
      bad++;
      $display("FAIL mid_access psel=%b penable=%b required 1 1", psel, penable);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({psel, penable, rsp_valid, cmd_ready, busy} !== 5'b0 || txn_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset psel=%b penable=%b rsp_valid=%b cmd_ready=%b busy=%b txn=%0d required all 0",
               psel, penable, rsp_valid, cmd_ready, busy, txn_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (!(cmd_ready === 1'b1 && psel === 1'b0 && busy === 1'b0)) begin
      bad++;
      $display("FAIL mid_release cmd_ready=%b psel=%b busy=%b required 1 0 0", cmd_ready, psel, busy);
    end
    pready = 1'b1;
    issue(32'hC000, 1'b1, 32'h9);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (!(rsp_valid === 1'b1 && rsp_err === 1'b0 && txn_count === 16'd1)) begin
      bad++;
      $display("FAIL mid_recover rsp_valid=%b err=%b txn=%0d required 1 0 1", rsp_valid, rsp_err, txn_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
